// File: rtl/mem_bus_arbiter_if.sv
// Shared-bus interface between the two masters (CPU, debug port), the
// arbiter and the memory decoder. The arbiter uses the slave view; the
// masters and the decoder together see the master view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cpu_ack;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_adr;
  logic [31:0]       dbg_wdata;
  logic [31:0]       dbg_rdata;
  logic              dbg_ack;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_adr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_adr, cpu_wdata,
    output cpu_rdata, cpu_ack,
    input  dbg_req, dbg_we, dbg_adr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_we, mem_adr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_adr, cpu_wdata,
    input  cpu_rdata, cpu_ack,
    output dbg_req, dbg_we, dbg_adr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_we, mem_adr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the memory-mapped data bus. One
// word access at a time: IDLE samples requests, ACCESS drives the bus for
// READ_LAT cycles and captures read data on the last one, ACK pulses the
// granted master's acknowledge for a single cycle.
module mem_bus_arbiter #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  mem_bus_arbiter_if.slave bus,
  output logic             owner,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic              owner_nxt;
  logic              grant_en;
  logic              capture;
  logic [3:0]        cnt;

  // Granted request, held for the whole transaction so a master may drop
  // or change its request lines once it has been granted.
  logic              g_we;
  logic [ADDR_W-1:0] g_adr;
  logic [31:0]       g_wdata;

  logic [31:0]       cpu_rdata_q;
  logic [31:0]       dbg_rdata_q;

  // Next-state decode; contention goes to the master that did not win last.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    grant_en  = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req || bus.dbg_req) begin
          grant_en  = 1'b1;
          state_nxt = ACCESS;
          if (bus.cpu_req && bus.dbg_req) owner_nxt = ~owner;
          else                            owner_nxt = bus.dbg_req;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant owner, busy flag and wait counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      owner <= 1'b1;
      busy  <= 1'b0;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      busy  <= (state_nxt != IDLE);
      if (grant_en)                           cnt <= LAT_M1;
      else if (state == ACCESS && cnt != 4'd0) cnt <= cnt - 4'd1;
    end
  end

  // Latch the winning master's request with the address word-aligned.
  always_ff @(posedge clk) begin
    if (grant_en) begin
      if (owner_nxt) begin
        g_we    <= bus.dbg_we;
        g_adr   <= {bus.dbg_adr[ADDR_W-1:2], 2'b00};
        g_wdata <= bus.dbg_wdata;
      end else begin
        g_we    <= bus.cpu_we;
        g_adr   <= {bus.cpu_adr[ADDR_W-1:2], 2'b00};
        g_wdata <= bus.cpu_wdata;
      end
    end
  end

  // Read data returned to each master, held until its next completed access.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpu_rdata_q <= 32'd0;
      dbg_rdata_q <= 32'd0;
    end else if (capture) begin
      if (owner) dbg_rdata_q <= bus.mem_rdata;
      else       cpu_rdata_q <= bus.mem_rdata;
    end
  end

  // Bus drive: quiet outside ACCESS, write strobe only on its first cycle.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_adr   = '0;
    bus.mem_wdata = 32'd0;
    if (state == ACCESS) begin
      bus.mem_we    = g_we && (cnt == LAT_M1);
      bus.mem_adr   = g_adr;
      bus.mem_wdata = g_wdata;
    end
  end

  assign bus.cpu_ack   = (state == ACK) && !owner;
  assign bus.dbg_ack   = (state == ACK) &&  owner;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances (READ_LAT 1, 3, 4) share the
// same master stimulus; each has its own memory stub and its own
// transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int NDUT   = 3;
  localparam int LAT[3] = '{1, 3, 4};

  logic        clk;
  logic        reset_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [31:0] cpu_adr, cpu_wdata, dbg_adr, dbg_wdata;

  logic [31:0] mem_adr_o[3], mem_wdata_o[3], cpu_rdata_o[3], dbg_rdata_o[3];
  logic        mem_we_o[3], cpu_ack_o[3], dbg_ack_o[3], owner_o[3], busy_o[3];

  int n_tests;
  int n_fail;

  // Memory stub contents as a pure function of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_0044) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : gl
    mem_bus_arbiter_if #(.ADDR_W(32)) bus ();

    assign bus.cpu_req   = cpu_req;
    assign bus.cpu_we    = cpu_we;
    assign bus.cpu_adr   = cpu_adr;
    assign bus.cpu_wdata = cpu_wdata;
    assign bus.dbg_req   = dbg_req;
    assign bus.dbg_we    = dbg_we;
    assign bus.dbg_adr   = dbg_adr;
    assign bus.dbg_wdata = dbg_wdata;
    assign bus.mem_rdata = memf(bus.mem_adr);

    mem_bus_arbiter #(
      .READ_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .ADDR_W  (32)
    ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus.slave),
      .owner  (owner_o[g]),
      .busy   (busy_o[g])
    );

    assign mem_adr_o[g]   = bus.mem_adr;
    assign mem_wdata_o[g] = bus.mem_wdata;
    assign mem_we_o[g]    = bus.mem_we;
    assign cpu_rdata_o[g] = bus.cpu_rdata;
    assign dbg_rdata_o[g] = bus.dbg_rdata;
    assign cpu_ack_o[g]   = bus.cpu_ack;
    assign dbg_ack_o[g]   = bus.dbg_ack;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one outstanding transaction per instance, described by
  // who owns it and how many edges have elapsed since the grant.
  bit          m_act[3];
  int          m_ph[3];
  bit          m_who[3];
  bit          m_owner[3];
  bit          m_we[3];
  logic [31:0] m_adr[3];
  logic [31:0] m_wd[3];
  logic [31:0] m_crd[3];
  logic [31:0] m_drd[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset_all();
    for (int k = 0; k < NDUT; k++) begin
      m_act[k]   = 1'b0;
      m_ph[k]    = 0;
      m_who[k]   = 1'b0;
      m_owner[k] = 1'b1;
      m_we[k]    = 1'b0;
      m_adr[k]   = 32'd0;
      m_wd[k]    = 32'd0;
      m_crd[k]   = 32'd0;
      m_drd[k]   = 32'd0;
    end
  endtask

  // Advance the model by one rising edge using the inputs present at it.
  task automatic model_edge();
    for (int k = 0; k < NDUT; k++) begin
      if (!reset_n) begin
        m_act[k]   = 1'b0;
        m_owner[k] = 1'b1;
        m_crd[k]   = 32'd0;
        m_drd[k]   = 32'd0;
      end else if (m_act[k]) begin
        m_ph[k]++;
        if (m_ph[k] == LAT[k]) begin
          if (m_who[k]) m_drd[k] = memf(m_adr[k]);
          else          m_crd[k] = memf(m_adr[k]);
        end else if (m_ph[k] == LAT[k] + 1) begin
          m_act[k] = 1'b0;
        end
      end else if (cpu_req || dbg_req) begin
        m_who[k]   = (cpu_req && dbg_req) ? !m_owner[k] : dbg_req;
        m_owner[k] = m_who[k];
        m_act[k]   = 1'b1;
        m_ph[k]    = 0;
        m_we[k]    = m_who[k] ? dbg_we : cpu_we;
        m_adr[k]   = (m_who[k] ? dbg_adr : cpu_adr) & 32'hFFFF_FFFC;
        m_wd[k]    = m_who[k] ? dbg_wdata : cpu_wdata;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NDUT; k++) begin
      bit acc;
      bit ackph;
      acc   = m_act[k] && (m_ph[k] < LAT[k]);
      ackph = m_act[k] && (m_ph[k] == LAT[k]);
      chk($sformatf("d%0d mem_adr", k),   mem_adr_o[k],   acc ? m_adr[k] : 32'd0);
      chk($sformatf("d%0d mem_wdata", k), mem_wdata_o[k], acc ? m_wd[k] : 32'd0);
      chk($sformatf("d%0d mem_we", k),    32'(mem_we_o[k]), 32'(acc && m_ph[k] == 0 && m_we[k]));
      chk($sformatf("d%0d cpu_ack", k),   32'(cpu_ack_o[k]), 32'(ackph && !m_who[k]));
      chk($sformatf("d%0d dbg_ack", k),   32'(dbg_ack_o[k]), 32'(ackph && m_who[k]));
      chk($sformatf("d%0d busy", k),      32'(busy_o[k]),  32'(m_act[k]));
      chk($sformatf("d%0d owner", k),     32'(owner_o[k]), 32'(m_owner[k]));
      chk($sformatf("d%0d cpu_rdata", k), cpu_rdata_o[k], m_crd[k]);
      chk($sformatf("d%0d dbg_rdata", k), dbg_rdata_o[k], m_drd[k]);
    end
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge,
  // where the caller then drives the next inputs.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_adr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    dbg_req = r; dbg_we = w; dbg_adr = a; dbg_wdata = d;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset_all();
    reset_n = 1'b0;
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dbg(1'b0, 1'b0, 32'd0, 32'd0);
    step(2);
    reset_n = 1'b1;
    step(1);

    // Single CPU read of 0x44.
    set_cpu(1'b1, 1'b0, 32'h0000_0044, 32'd0);
    step(1);
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    step(6);
    for (int k = 0; k < NDUT; k++)
      chk($sformatf("d%0d read_44", k), cpu_rdata_o[k], 32'hDEAD_BEEF);

    // Unaligned debug write, request pulsed for a single cycle.
    set_dbg(1'b1, 1'b1, 32'h0000_0083, 32'h1234_5678);
    step(1);
    set_dbg(1'b0, 1'b0, 32'd0, 32'd0);
    step(7);

    // Contention from reset: CPU first, then alternating.
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    set_cpu(1'b1, 1'b0, 32'h0000_0100, 32'd0);
    set_dbg(1'b1, 1'b0, 32'h0000_0204, 32'd0);
    step(1);
    for (int k = 0; k < NDUT; k++)
      chk($sformatf("d%0d first_grant", k), 32'(owner_o[k]), 32'd0);
    step(24);
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dbg(1'b0, 1'b0, 32'd0, 32'd0);
    step(7);

    // CPU write held over a long access, then reset during its second cycle.
    set_cpu(1'b1, 1'b1, 32'h0000_0300, 32'hCAFE_0001);
    step(1);
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    step(1);
    reset_n = 1'b0;
    step(1);
    chk("d1 reset_busy",  32'(busy_o[1]),  32'd0);
    chk("d1 reset_adr",   mem_adr_o[1],    32'd0);
    chk("d1 reset_owner", 32'(owner_o[1]), 32'd1);
    reset_n = 1'b1;
    set_cpu(1'b1, 1'b0, 32'h0000_0044, 32'd0);
    set_dbg(1'b1, 1'b0, 32'h0000_0048, 32'd0);
    step(1);
    for (int k = 0; k < NDUT; k++)
      chk($sformatf("d%0d post_reset_grant", k), 32'(owner_o[k]), 32'd0);
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dbg(1'b0, 1'b0, 32'd0, 32'd0);
    step(12);

    // CPU write that runs to completion on every latency.
    set_cpu(1'b1, 1'b1, 32'h0000_0401, 32'h0BAD_F00D);
    step(1);
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    step(7);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      set_cpu($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              $urandom & 32'h0000_0FFF, $urandom);
      set_dbg($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              $urandom & 32'h0000_0FFF, $urandom);
      step(1);
    end

    reset_n = 1'b1;
    set_cpu(1'b0, 1'b0, 32'd0, 32'd0);
    set_dbg(1'b0, 1'b0, 32'd0, 32'd0);
    step(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
